multicycle_controller_ws: RTL

//  Next-generation RISC-V multicycle control unit. Drives the same datapath as the current controller and adds:

---
 rtl/multicycle_controller_ws_if.sv | 20 ++
 rtl/multicycle_controller_ws.sv | 96 +++++++++
 2 files changed

// File: rtl/multicycle_controller_ws_if.sv
// multicycle_controller_ws_if: instruction fields, memory handshake and datapath controls of the multicycle controller
interface multicycle_controller_ws_if #(parameter int CNT_W = 32);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, MemReady;
  logic [2:0] ImmSrc, ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, TrapCause;
  logic AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Trap;
  logic [CNT_W-1:0] InstrCount;
  modport master(
    input op, funct3, funct7b5, Zero, MemReady,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, MemWrite,
    output MemReq, Trap, TrapCause, InstrCount
  );
  modport slave(
    output op, funct3, funct7b5, Zero, MemReady,
    input ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, MemWrite,
    input MemReq, Trap, TrapCause, InstrCount
  );
endinterface

// File: rtl/multicycle_controller_ws.sv
// multicycle_controller_ws: RISC-V multicycle control FSM with memory wait states, timeout trap and retire counter
module multicycle_controller_ws #(
  parameter bit EXT_EN = 1'b1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_ws_if.master bus
);
  localparam int WW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, JAL, BEQ, LUI, JALR_A, TRAP
  } state_t;
  state_t state_q, state_d, disp;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_st, timeout;
  logic [2:0] alu_dec;
  always_comb begin
    mem_st = state_q inside {FETCH, MEM_READ, MEM_WRITE};
    timeout = mem_st && !bus.MemReady && TIMEOUT != 0 && wait_q == WW'(TIMEOUT - 1);
    case (bus.op)
      7'b0000011, 7'b0100011: disp = MEM_ADR;
      7'b0110011: disp = EXEC_R;
      7'b0010011: disp = EXEC_I;
      7'b1101111: disp = JAL;
      7'b1100011: disp = (bus.funct3 == 3'b000 || (EXT_EN && bus.funct3 == 3'b001)) ? BEQ : TRAP;
      7'b0110111: disp = EXT_EN ? LUI : TRAP;
      7'b1100111: disp = (EXT_EN && bus.funct3 == 3'b000) ? JALR_A : TRAP;
      default: disp = TRAP;
    endcase
    case (state_q)
      FETCH: state_d = bus.MemReady ? DECODE : FETCH;
      DECODE: state_d = disp;
      MEM_ADR: state_d = bus.op[5] ? MEM_WRITE : MEM_READ;
      MEM_READ: state_d = bus.MemReady ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = bus.MemReady ? FETCH : MEM_WRITE;
      EXEC_R, EXEC_I, JAL: state_d = ALU_WB;
      JALR_A: state_d = JAL;
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = TRAP;
    cause_d = (state_q != TRAP && state_d == TRAP) ? (timeout ? 2'b10 : 2'b01) : cause_q;
    wait_d = (mem_st && !bus.MemReady && !timeout) ? wait_q + 1'b1 : '0;
    cnt_d = cnt_q + CNT_W'(state_d == FETCH && state_q != FETCH);
  end
  always_comb begin
    case (bus.funct3)
      3'b000: alu_dec = {2'b00, bus.funct7b5 & bus.op[5]};
      3'b010: alu_dec = 3'b101;
      3'b110: alu_dec = 3'b011;
      3'b111: alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
    case (bus.op)
      7'b0100011: bus.ImmSrc = 3'b001;
      7'b1100011: bus.ImmSrc = 3'b010;
      7'b1101111: bus.ImmSrc = 3'b011;
      7'b0110111: bus.ImmSrc = 3'b100;
      default: bus.ImmSrc = 3'b000;
    endcase
    bus.ALUSrcA = state_q inside {DECODE, JAL} ? 2'b01 :
                  state_q inside {MEM_ADR, EXEC_R, EXEC_I, BEQ, JALR_A} ? 2'b10 : 2'b00;
    bus.ALUSrcB = state_q inside {FETCH, JAL} ? 2'b10 :
                  state_q inside {DECODE, MEM_ADR, EXEC_I, JALR_A} ? 2'b01 : 2'b00;
    bus.ResultSrc = state_q == FETCH ? 2'b10 : state_q == MEM_WB ? 2'b01 : state_q == LUI ? 2'b11 : 2'b00;
    bus.AdrSrc = state_q inside {MEM_READ, MEM_WRITE};
    bus.ALUControl = state_q inside {EXEC_R, EXEC_I} ? alu_dec : state_q == BEQ ? 3'b001 : 3'b000;
    bus.IRWrite = state_q == FETCH && bus.MemReady;
    // bne reuses BEQ: funct3[0] inverts the taken condition
    bus.PCWrite = (state_q == FETCH && bus.MemReady) || state_q == JAL ||
                  (state_q == BEQ && (bus.Zero ^ bus.funct3[0]));
    bus.RegWrite = state_q inside {MEM_WB, ALU_WB, LUI};
    bus.MemWrite = state_q == MEM_WRITE;
    bus.MemReq = mem_st;
    bus.Trap = state_q == TRAP;
    bus.TrapCause = cause_q;
    bus.InstrCount = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q <= '0;
      cause_q <= 2'b00;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
